// File: rtl/ex_alu_mdu.sv
// Execute-stage unit: combinational ALU with flags, plus an iterative
// multiply/divide unit that owns the HI/LO registers.
module ex_alu_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  input  logic [2:0]       MDOp,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = SW + 1;

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_e;

  // ------------------------------------------------------------------ ALU
  logic [WIDTH-1:0] sum, diff;
  logic [SW-1:0]    shamt;

  always_comb begin
    sum      = A + B;
    diff     = A - B;
    shamt    = B[SW-1:0];
    Result   = '0;
    Overflow = 1'b0;
    case (ALUOp)
      4'd0:  Result = A & B;
      4'd1:  Result = A | B;
      4'd2: begin
        Result   = sum;
        Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'd3: begin
        Result   = diff;
        Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      4'd4:  Result = A << shamt;
      4'd5:  Result = A >> shamt;
      4'd6:  Result = WIDTH'($signed(A) >>> shamt);
      4'd7:  Result = A ^ B;
      4'd8:  Result = ~(A | B);
      4'd9:  Result = WIDTH'($signed(A) < $signed(B));
      4'd10: Result = WIDTH'(A < B);
      4'd11: Result = B << (WIDTH / 2);
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

  // ------------------------------------------------------------------ MDU
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] bm_q, bm_d;
  logic [WIDTH-1:0] hi_acc_q, hi_acc_d;
  logic [WIDTH-1:0] lo_acc_q, lo_acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH:0]     mul_sum, rem_sh, rem_try;
  logic [WIDTH-1:0]   step_hi, step_lo, fin_hi, fin_lo;
  logic [2*WIDTH-1:0] prod;
  logic               sgn, sa, sb;

  // One iteration step: hi_acc/lo_acc hold product-high/multiplier for
  // multiply, and partial remainder/dividend-becoming-quotient for divide.
  always_comb begin
    mul_sum = {1'b0, hi_acc_q} + (lo_acc_q[0] ? {1'b0, bm_q} : '0);
    rem_sh  = {hi_acc_q, lo_acc_q[WIDTH-1]};
    rem_try = rem_sh - {1'b0, bm_q};
    if (is_div_q) begin
      if (!rem_try[WIDTH]) begin
        step_hi = rem_try[WIDTH-1:0];
        step_lo = {lo_acc_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = rem_sh[WIDTH-1:0];
        step_lo = {lo_acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_acc_q[WIDTH-1:1]};
    end

    prod = {step_hi, step_lo};
    if (neg_lo_q) prod = -prod;
    if (is_div_q) begin
      fin_lo = neg_lo_q ? -step_lo : step_lo;
      fin_hi = neg_hi_q ? -step_hi : step_hi;
      if (div0_q) begin
        fin_hi = a_raw_q;
        fin_lo = '1;
      end
    end else begin
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end
  end

  // Next-state: accept in IDLE, iterate in RUN, commit HI/LO on the last step.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    a_raw_d  = a_raw_q;
    bm_d     = bm_q;
    hi_acc_d = hi_acc_q;
    lo_acc_d = lo_acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    sgn = (MDOp == MD_MULT) || (MDOp == MD_DIV);
    sa  = sgn & A[WIDTH-1];
    sb  = sgn & B[WIDTH-1];

    case (state_q)
      IDLE: begin
        if (Start) begin
          case (MDOp)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_d  = RUN;
              cnt_d    = CW'(WIDTH);
              is_div_d = (MDOp == MD_DIV) || (MDOp == MD_DIVU);
              neg_lo_d = sa ^ sb;
              neg_hi_d = sa;
              div0_d   = (B == '0);
              a_raw_d  = A;
              bm_d     = sb ? -B : B;
              hi_acc_d = '0;
              lo_acc_d = sa ? -A : A;
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d    = cnt_q - CW'(1);
        hi_acc_d = step_hi;
        lo_acc_d = step_lo;
        if (cnt_q == CW'(1)) begin
          hi_d    = fin_hi;
          lo_d    = fin_lo;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      a_raw_q  <= '0;
      bm_q     <= '0;
      hi_acc_q <= '0;
      lo_acc_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      a_raw_q  <= a_raw_d;
      bm_q     <= bm_d;
      hi_acc_q <= hi_acc_d;
      lo_acc_q <= lo_acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign Busy = (state_q == RUN);
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_ex_alu_mdu.sv
// Directed bench for ex_alu_mdu: 32-bit instance for ALU/MDU behaviour and a
// 16-bit instance for the narrow-width multiply.
module tb_ex_alu_mdu;

  logic        clk;
  logic        reset;
  logic [31:0] a, b;
  logic [3:0]  aluop;
  logic [2:0]  mdop;
  logic        start;
  logic [31:0] result, hi, lo;
  logic        zero, ovf, busy, done;

  logic [15:0] a16, b16, result16, hi16, lo16;
  logic [3:0]  aluop16;
  logic [2:0]  mdop16;
  logic        start16, zero16, ovf16, busy16, done16;

  int checks;
  int failures;
  int bc;
  int dp;

  ex_alu_mdu #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .A(a), .B(b), .ALUOp(aluop),
    .Result(result), .Zero(zero), .Overflow(ovf),
    .MDOp(mdop), .Start(start), .Busy(busy), .Done(done),
    .HI(hi), .LO(lo)
  );

  ex_alu_mdu #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .A(a16), .B(b16), .ALUOp(aluop16),
    .Result(result16), .Zero(zero16), .Overflow(ovf16),
    .MDOp(mdop16), .Start(start16), .Busy(busy16), .Done(done16),
    .HI(hi16), .LO(lo16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    mdop  = op;
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    mdop  = 3'd0;
  endtask

  // Counts cycles Busy stays high and Done pulses, including one cycle after.
  task automatic wait_idle(output int busy_cycles, output int done_pulses);
    busy_cycles = 0;
    done_pulses = 0;
    while (busy && busy_cycles < 200) begin
      tick();
      busy_cycles++;
      if (done) done_pulses++;
    end
    tick();
    if (done) done_pulses++;
  endtask

  task automatic alu(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    aluop = op;
    a     = av;
    b     = bv;
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; a = '0; b = '0; aluop = '0; mdop = '0; start = 1'b0;
    a16 = '0; b16 = '0; aluop16 = '0; mdop16 = '0; start16 = 1'b0;
    #12;
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    reset = 1'b1;
    tick();

    // MTHI/MTLO: immediate write, no busy/done
    start_op(3'd5, 32'h0000_0055, 32'h0);
    chk("mthi_hi", 64'(hi), 64'h55);
    chk("mthi_busy", 64'(busy), 64'h0);
    start_op(3'd6, 32'h0000_0066, 32'h0);
    chk("mtlo_lo", 64'(lo), 64'h66);
    chk("mtlo_done", 64'(done), 64'h0);

    // Reset mid-DIV, counter around 10
    start_op(3'd3, 32'd1000, 32'd3);
    for (int i = 0; i < 22; i++) tick();
    chk("mid_busy", 64'(busy), 64'h1);
    reset = 1'b0;
    #1;
    chk("abort_hi", 64'(hi), 64'h0);
    chk("abort_lo", 64'(lo), 64'h0);
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_done", 64'(done), 64'h0);
    #3;
    reset = 1'b1;
    tick();

    // DIVU 100/7 right after reset
    start_op(3'd4, 32'd100, 32'd7);
    chk("divu_accept", 64'(busy), 64'h1);
    wait_idle(bc, dp);
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);

    // MULT -3 * 7
    start_op(3'd1, 32'hFFFF_FFFD, 32'd7);
    wait_idle(bc, dp);
    chk("mult_busy_cycles", 64'(bc), 64'd32);
    chk("mult_done_pulses", 64'(dp), 64'd1);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);

    // MULTU max*max
    start_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(bc, dp);
    chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h0000_0001);

    // DIV -7/2
    start_op(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(bc, dp);
    chk("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

    // DIV MIN / -1
    start_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(bc, dp);
    chk("div_min_lo", 64'(lo), 64'h8000_0000);
    chk("div_min_hi", 64'(hi), 64'h0);

    // DIVU by zero
    start_op(3'd4, 32'h1234_5678, 32'h0);
    wait_idle(bc, dp);
    chk("divu0_busy_cycles", 64'(bc), 64'd32);
    chk("divu0_hi", 64'(hi), 64'h1234_5678);
    chk("divu0_lo", 64'(lo), 64'hFFFF_FFFF);

    // DIV by zero, negative dividend
    start_op(3'd3, 32'hFFFF_FFFB, 32'h0);
    wait_idle(bc, dp);
    chk("div0_hi", 64'(hi), 64'hFFFF_FFFB);
    chk("div0_lo", 64'(lo), 64'hFFFF_FFFF);

    // MTHI while busy is ignored; operand change mid-op has no effect; ALU usable
    start_op(3'd1, 32'd3, 32'd5);
    for (int i = 0; i < 10; i++) tick();
    alu(4'd2, 32'd1, 32'd2);
    chk("alu_while_busy", 64'(result), 64'd3);
    a = 32'h0000_ABCD; mdop = 3'd5; start = 1'b1;
    tick();
    start = 1'b0; mdop = 3'd0;
    chk("mthi_ignored_now", 64'(hi), 64'hFFFF_FFFB);
    wait_idle(bc, dp);
    chk("busy_mthi_hi", 64'(hi), 64'h0);
    chk("busy_mthi_lo", 64'(lo), 64'd15);
    start_op(3'd5, 32'h0000_ABCD, 32'h0);
    chk("mthi_after_hi", 64'(hi), 64'h0000_ABCD);
    chk("mthi_after_busy", 64'(busy), 64'h0);
    chk("mthi_after_done", 64'(done), 64'h0);
    start_op(3'd7, 32'h1111_1111, 32'h2);
    chk("op7_busy", 64'(busy), 64'h0);
    chk("op7_hi", 64'(hi), 64'h0000_ABCD);

    // ALU sweep
    alu(4'd6, 32'h8000_0000, 32'd4);
    chk("sra", 64'(result), 64'hF800_0000);
    alu(4'd9, 32'hFFFF_FFFF, 32'd1);
    chk("slt", 64'(result), 64'd1);
    alu(4'd10, 32'hFFFF_FFFF, 32'd1);
    chk("sltu", 64'(result), 64'd0);
    alu(4'd2, 32'h7FFF_FFFF, 32'd1);
    chk("add_res", 64'(result), 64'h8000_0000);
    chk("add_ovf", 64'(ovf), 64'h1);
    alu(4'd3, 32'd5, 32'd5);
    chk("sub_zero", 64'(zero), 64'h1);
    chk("sub_ovf", 64'(ovf), 64'h0);
    alu(4'd3, 32'h8000_0000, 32'd1);
    chk("sub_ovf_min", 64'(ovf), 64'h1);
    alu(4'd11, 32'h0, 32'h1234);
    chk("lui", 64'(result), 64'h1234_0000);
    alu(4'd8, 32'h0F0F_0000, 32'h0000_00F0);
    chk("nor", 64'(result), 64'hF0F0_FF0F);
    alu(4'd4, 32'h0000_0001, 32'h0000_0025);
    chk("sll_low_bits", 64'(result), 64'h0000_0020);
    alu(4'd5, 32'h8000_0000, 32'd4);
    chk("srl", 64'(result), 64'h0800_0000);
    alu(4'd7, 32'hFFFF_0000, 32'h0F0F_0F0F);
    chk("xor", 64'(result), 64'hF0F0_0F0F);
    alu(4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("and_no_ovf", 64'(ovf), 64'h0);
    alu(4'd13, 32'hFFFF_FFFF, 32'h1);
    chk("op13_zero", 64'(result), 64'h0);

    // 16-bit instance: MULTU 0xFFFF * 2
    mdop16 = 3'd2; a16 = 16'hFFFF; b16 = 16'h0002; start16 = 1'b1;
    tick();
    start16 = 1'b0; mdop16 = 3'd0;
    bc = 0;
    while (busy16 && bc < 200) begin
      tick();
      bc++;
    end
    chk("w16_busy_cycles", 64'(bc), 64'd16);
    chk("w16_done", 64'(done16), 64'h1);
    chk("w16_hi", 64'(hi16), 64'h0001);
    chk("w16_lo", 64'(lo16), 64'hFFFE);
    aluop16 = 4'd11; b16 = 16'h00AB;
    #1;
    chk("w16_lui", 64'(result16), 64'hAB00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_alu_mdu.md
Name: ex_alu_mdu

Overview:
Parametrised next-generation execute-stage unit. Combinational ALU (widened op set, signed overflow and zero flags) plus an iterative multiply/divide unit (MDU) with HI/LO registers. The MDU uses a start/busy/done handshake, and decode stalls while Busy=1. It sits in the EX stage after operand-source muxing. The EX control decoder drives ALUOp, MDOp and Start.

Parameters:
WIDTH, 32, datapath width in bits; must be even and at least 8; shift amount uses the low clog2(WIDTH) bits of B.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
A  input  WIDTH  operand A
B  input  WIDTH  operand B
ALUOp  input  4  combinational ALU operation select
Result  output  WIDTH  combinational ALU result
Zero  output  1  Result == 0
Overflow  output  1  signed overflow; ADD/SUB only
MDOp  input  3  MDU op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none
Start  input  1  MDU request, sampled on rising edge
Busy  output  1  MDU iterating; new requests ignored
Done  output  1  one-cycle pulse when HI/LO are updated by MULT/DIV
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous, effective immediately): HI=0, LO=0, Busy=0, Done=0, iteration counter=0. Any operation in flight is aborted and its result discarded.
- ALU (combinational, zero latency), by ALUOp:
  - 0 AND, 1 OR, 2 ADD, 3 SUB
  - 4 SLL, 5 SRL, 6 SRA (shift A by B[clog2(WIDTH)-1:0])
  - 7 XOR, 8 NOR
  - 9 SLT (signed, result 1/0), 10 SLTU (unsigned, result 1/0)
  - 11 LUI: B << WIDTH/2
  - 12-15: Result=0
- ADD/SUB wrap modulo 2^WIDTH. Overflow=1 only on signed overflow of ADD/SUB; 0 for every other op.
- MDU FSM states: IDLE, RUN.
- IDLE, Start=1, MDOp in 1..4:
  - Latch operands: magnitudes plus sign flags for signed ops.
  - Load counter=WIDTH; Busy=1 from the next edge.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter decrements.
- Completion edge (counter reaches 0):
  - HI/LO written with sign correction applied.
  - Busy=0, Done=1 for exactly one cycle; return to IDLE.
  - Busy is high for exactly WIDTH cycles. New HI/LO are visible the cycle Busy falls.
- MULT/MULTU: {HI,LO} = full 2*WIDTH-bit product.
- DIV/DIVU: LO=quotient, HI=remainder. Signed quotient truncates toward zero; remainder takes the dividend's sign.
- Signed DIV of MIN by -1: LO=MIN, HI=0.
- Divide by zero (signed or unsigned): full latency; HI=A (as latched), LO=all ones.
- IDLE, Start=1, MDOp=5 (MTHI) or 6 (MTLO): HI (resp. LO)=A at that edge. Busy and Done stay 0.
- Start with MDOp 0/7: no effect.
- Start while Busy=1: ignored entirely, including MTHI/MTLO.
- Operands are sampled only at the accepting edge; later changes to A/B do not affect the running op.
- HI/LO hold their values otherwise. The ALU stays usable while Busy=1.

Test Plan:
1. Assert reset=0 mid-DIV (counter ~10) -> HI=LO=0, Busy=0, Done=0 immediately. Release reset -> IDLE; next Start is accepted.
2. MULT, A=0xFFFFFFFD (-3), B=7 -> Busy high exactly 32 cycles, one Done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
3. Division results:
   - DIVU 100/7 -> LO=14, HI=2.
   - DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
4. DIVU A=0x12345678, B=0 -> after 32 cycles HI=0x12345678, LO=0xFFFFFFFF.
5. During a MULT, pulse Start with MDOp=5, A=0xABCD -> HI is unaffected by the MTHI and ends as the product. After Busy falls, MTHI A=0xABCD -> HI=0x0000ABCD next edge, Busy and Done stay 0.
6. ALU sweep (WIDTH=32):
   - SRA 0x80000000 by 4 -> 0xF8000000
   - SLT -1,1 -> 1; SLTU -1,1 -> 0
   - ADD 0x7FFFFFFF+1 -> 0x80000000, Overflow=1
   - SUB 5-5 -> Zero=1
   - LUI B=0x1234 -> 0x12340000
   - Rerun with WIDTH=16: MULTU 0xFFFF*2 -> HI=0x0001, LO=0xFFFE.
